hazard_stall_ctrl: RTL and testbench

//  Pipeline sequencer for the FE/DE/AGEX latches around the decode stage.

---
 rtl/hazard_stall_ctrl.sv | 174 +++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage pipeline sequencer: load-use bubbles, branch wait, ECALL drain/halt, MEM_STALL freeze.
// Optional performance counters are compiled in when HAZ_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
    parameter int BR_TIMEOUT   = 15,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              DE_V,
    input  logic [31:0]       DE_IR,
    input  logic              EXE_V,
    input  logic [31:0]       EXE_IR,
    input  logic [4:0]        EXE_DRID,
    input  logic              MEM_STALL,
    input  logic              EXE_BR_RES,
    input  logic              EXE_BR_TAKEN,
    input  logic              RESUME,
    output logic              LD_FE,
    output logic              LD_DE,
    output logic              LD_AGEX,
    output logic              DE_V_IN,
    output logic              EXE_V_IN,
    output logic              FE_FLUSH,
    output logic              V_DE_BR_STALL,
    output logic              HALTED,
`ifdef HAZ_PERF_CNT_EN
    output logic [CNT_W-1:0]  LDUSE_CNT,
    output logic [CNT_W-1:0]  BRWAIT_CNT,
    output logic [CNT_W-1:0]  MEMSTALL_CNT,
`endif
    output logic              BR_ERR
);

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] BR_WAIT = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;
    localparam logic [1:0] HALT    = 2'd3;

    localparam int CNT_MAX = (BR_TIMEOUT > DRAIN_CYCLES) ? BR_TIMEOUT : DRAIN_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] BR_LAST = CW'(BR_TIMEOUT - 1);
    localparam logic [CW-1:0] DR_LAST = CW'(DRAIN_CYCLES - 1);

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          br_timeout;
    logic          lduse_evt;

    logic [6:0] de_op;
    logic [4:0] rs1, rs2;
    logic       rs1_used, rs2_used, exe_is_load, load_use;
    logic       de_is_ctrl, de_is_ecall;
    logic       unused_exe_ir;

    assign de_op = DE_IR[6:0];
    assign rs1   = DE_IR[19:15];
    assign rs2   = DE_IR[24:20];

    // CSR immediate forms (funct3[2]=1) put a zimm, not a register, in the rs1 field.
    assign rs1_used = !(de_op == 7'b0110111 || de_op == 7'b0010111 || de_op == 7'b1101111 ||
                        (de_op == 7'b1110011 && DE_IR[14]));
    assign rs2_used = (de_op == 7'b0110011) || (de_op == 7'b0111011) ||
                      (de_op == 7'b0100011) || (de_op == 7'b1100011);

    assign exe_is_load = EXE_V && (EXE_IR[6:0] == 7'b0000011) && (EXE_DRID != 5'd0);
    assign load_use    = exe_is_load && DE_V &&
                         ((rs1_used && rs1 == EXE_DRID) || (rs2_used && rs2 == EXE_DRID));

    assign de_is_ctrl  = (de_op == 7'b1100011) || (de_op == 7'b1101111) || (de_op == 7'b1100111);
    assign de_is_ecall = (DE_IR == 32'h0000_0073);
    assign unused_exe_ir = ^EXE_IR[31:7];

    assign V_DE_BR_STALL = (state == BR_WAIT);

    always_comb begin
        LD_FE      = 1'b0;
        LD_DE      = 1'b0;
        LD_AGEX    = 1'b0;
        DE_V_IN    = 1'b0;
        EXE_V_IN   = 1'b0;
        FE_FLUSH   = 1'b0;
        state_nxt  = state;
        cnt_nxt    = cnt;
        br_timeout = 1'b0;
        lduse_evt  = 1'b0;
        if (RESET) begin
            LD_FE   = 1'b1;
            LD_DE   = 1'b1;
            LD_AGEX = 1'b1;
        end else if (!MEM_STALL) begin
            case (state)
                RUN: begin
                    if (load_use) begin
                        LD_AGEX   = 1'b1;
                        DE_V_IN   = 1'b1;
                        lduse_evt = 1'b1;
                    end else begin
                        LD_FE    = 1'b1;
                        LD_DE    = 1'b1;
                        LD_AGEX  = 1'b1;
                        DE_V_IN  = 1'b1;
                        EXE_V_IN = DE_V;
                        if (DE_V && de_is_ctrl) begin
                            state_nxt = BR_WAIT;
                            cnt_nxt   = '0;
                        end else if (DE_V && de_is_ecall) begin
                            state_nxt = DRAIN;
                            cnt_nxt   = '0;
                        end
                    end
                end
                BR_WAIT: begin
                    LD_DE   = 1'b1;
                    LD_AGEX = 1'b1;
                    cnt_nxt = cnt + 1'b1;
                    if (EXE_BR_RES) begin
                        LD_FE     = 1'b1;
                        FE_FLUSH  = EXE_BR_TAKEN;
                        state_nxt = RUN;
                    end else if (cnt == BR_LAST) begin
                        LD_FE      = 1'b1;
                        br_timeout = 1'b1;
                        state_nxt  = RUN;
                    end
                end
                DRAIN: begin
                    LD_DE   = 1'b1;
                    LD_AGEX = 1'b1;
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == DR_LAST) state_nxt = HALT;
                end
                HALT: begin
                    if (RESUME) state_nxt = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= RUN;
            cnt    <= '0;
            HALTED <= 1'b0;
            BR_ERR <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            HALTED <= (state_nxt == HALT);
            if (br_timeout) BR_ERR <= 1'b1;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            LDUSE_CNT    <= '0;
            BRWAIT_CNT   <= '0;
            MEMSTALL_CNT <= '0;
        end else begin
            if (lduse_evt)          LDUSE_CNT    <= LDUSE_CNT + 1'b1;
            if (state == BR_WAIT)   BRWAIT_CNT   <= BRWAIT_CNT + 1'b1;
            if (MEM_STALL)          MEMSTALL_CNT <= MEMSTALL_CNT + 1'b1;
        end
    end
`else
    logic unused_perf;
    logic [CNT_W-1:0] unused_perf_w;
    assign unused_perf_w = '0;
    assign unused_perf   = lduse_evt ^ (^unused_perf_w);
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: table of load-use vectors plus multi-cycle FSM sequences.
module tb_hazard_stall_ctrl;

    logic        CLK = 1'b0;
    logic        RESET, DE_V, EXE_V, MEM_STALL, EXE_BR_RES, EXE_BR_TAKEN, RESUME;
    logic [31:0] DE_IR, EXE_IR;
    logic [4:0]  EXE_DRID;
    logic        LD_FE, LD_DE, LD_AGEX, DE_V_IN, EXE_V_IN, FE_FLUSH, V_DE_BR_STALL, HALTED, BR_ERR;

    int total = 0;
    int bad   = 0;

    hazard_stall_ctrl #(.BR_TIMEOUT(15), .DRAIN_CYCLES(3), .CNT_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .DE_V(DE_V), .DE_IR(DE_IR), .EXE_V(EXE_V), .EXE_IR(EXE_IR),
        .EXE_DRID(EXE_DRID), .MEM_STALL(MEM_STALL), .EXE_BR_RES(EXE_BR_RES),
        .EXE_BR_TAKEN(EXE_BR_TAKEN), .RESUME(RESUME), .LD_FE(LD_FE), .LD_DE(LD_DE),
        .LD_AGEX(LD_AGEX), .DE_V_IN(DE_V_IN), .EXE_V_IN(EXE_V_IN), .FE_FLUSH(FE_FLUSH),
        .V_DE_BR_STALL(V_DE_BR_STALL), .HALTED(HALTED), .BR_ERR(BR_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        de_v;
        logic [31:0] de_ir;
        logic        exe_v;
        logic [31:0] exe_ir;
        logic [4:0]  drid;
        logic        exp_ld_fe;
        logic        exp_ld_de;
        logic        exp_exe_v_in;
    } vec_t;

    localparam logic [31:0] LW_X5   = 32'h0000A283;
    localparam logic [31:0] LW_X0   = 32'h0000A003;
    localparam logic [31:0] ADD_R1  = 32'h00728333;  // add x6,x5,x7
    localparam logic [31:0] BEQ_00  = 32'h00000063;
    localparam logic [31:0] JAL_00  = 32'h0000006F;
    localparam logic [31:0] ECALL   = 32'h00000073;

    vec_t vecs [15];

    task automatic chk(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        DE_V = 1'b0; DE_IR = '0; EXE_V = 1'b0; EXE_IR = '0; EXE_DRID = '0;
        MEM_STALL = 1'b0; EXE_BR_RES = 1'b0; EXE_BR_TAKEN = 1'b0; RESUME = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ir);
        @(negedge CLK);
        clear_inputs();
        DE_V = 1'b1; DE_IR = ir;
        #1;
        chk("issue_ld_fe", LD_FE, 1'b1);
        chk("issue_exe_v_in", EXE_V_IN, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, ADD_R1,        1'b1, LW_X5,  5'd5, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'h00538333,  1'b1, LW_X5,  5'd5, 1'b0, 1'b0, 1'b0}; // add rs2 hit
        vecs[2]  = '{1'b1, 32'h00128313,  1'b1, LW_X5,  5'd5, 1'b0, 1'b0, 1'b0}; // addi rs1 hit
        vecs[3]  = '{1'b1, 32'h00538313,  1'b1, LW_X5,  5'd5, 1'b1, 1'b1, 1'b1}; // addi imm==5 only
        vecs[4]  = '{1'b1, 32'h00028337,  1'b1, LW_X5,  5'd5, 1'b1, 1'b1, 1'b1}; // lui
        vecs[5]  = '{1'b1, 32'h00028317,  1'b1, LW_X5,  5'd5, 1'b1, 1'b1, 1'b1}; // auipc
        vecs[6]  = '{1'b1, 32'h0002D373,  1'b1, LW_X5,  5'd5, 1'b1, 1'b1, 1'b1}; // csrrwi
        vecs[7]  = '{1'b1, 32'h00029373,  1'b1, LW_X5,  5'd5, 1'b0, 1'b0, 1'b0}; // csrrw
        vecs[8]  = '{1'b1, 32'h0050A023,  1'b1, LW_X5,  5'd5, 1'b0, 1'b0, 1'b0}; // sw rs2 hit
        vecs[9]  = '{1'b1, 32'h0053833B,  1'b1, LW_X5,  5'd5, 1'b0, 1'b0, 1'b0}; // addw rs2 hit
        vecs[10] = '{1'b1, ADD_R1,        1'b0, LW_X5,  5'd5, 1'b1, 1'b1, 1'b1}; // exe invalid
        vecs[11] = '{1'b1, ADD_R1,        1'b1, ADD_R1, 5'd5, 1'b1, 1'b1, 1'b1}; // exe not a load
        vecs[12] = '{1'b1, 32'h00700333,  1'b1, LW_X0,  5'd0, 1'b1, 1'b1, 1'b1}; // lw x0
        vecs[13] = '{1'b0, ADD_R1,        1'b1, LW_X5,  5'd5, 1'b1, 1'b1, 1'b0}; // de invalid
        vecs[14] = '{1'b1, 32'h00028063,  1'b1, LW_X5,  5'd5, 1'b0, 1'b0, 1'b0}; // beq x5 hit

        clear_inputs();
        RESET = 1'b1;
        @(negedge CLK); #1;
        chk("rst_ld_fe", LD_FE, 1'b1);
        chk("rst_ld_de", LD_DE, 1'b1);
        chk("rst_ld_agex", LD_AGEX, 1'b1);
        chk("rst_de_v_in", DE_V_IN, 1'b0);
        chk("rst_exe_v_in", EXE_V_IN, 1'b0);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("rst_halted", HALTED, 1'b0);
        chk("rst_br_err", BR_ERR, 1'b0);
        chk("rst_br_stall", V_DE_BR_STALL, 1'b0);
        chk("rst_fe_flush", FE_FLUSH, 1'b0);

        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            clear_inputs();
            DE_V = vecs[i].de_v; DE_IR = vecs[i].de_ir;
            EXE_V = vecs[i].exe_v; EXE_IR = vecs[i].exe_ir; EXE_DRID = vecs[i].drid;
            #1;
            chk($sformatf("vec%0d_ld_fe", i), LD_FE, vecs[i].exp_ld_fe);
            chk($sformatf("vec%0d_ld_de", i), LD_DE, vecs[i].exp_ld_de);
            chk($sformatf("vec%0d_ld_agex", i), LD_AGEX, 1'b1);
            chk($sformatf("vec%0d_exe_v_in", i), EXE_V_IN, vecs[i].exp_exe_v_in);
        end

        // load-use bubble, then the bubble reaches EXE and flow resumes
        @(negedge CLK);
        clear_inputs();
        DE_V = 1'b1; DE_IR = ADD_R1; EXE_V = 1'b1; EXE_IR = LW_X5; EXE_DRID = 5'd5;
        #1;
        chk("lu_stall_ld_fe", LD_FE, 1'b0);
        @(negedge CLK);
        EXE_V = 1'b0;
        #1;
        chk("lu_after_ld_fe", LD_FE, 1'b1);
        chk("lu_after_ld_de", LD_DE, 1'b1);
        chk("lu_after_exe_v_in", EXE_V_IN, 1'b1);

        // branch resolved taken on third wait cycle
        issue(BEQ_00);
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            clear_inputs();
            EXE_BR_RES = (c == 2); EXE_BR_TAKEN = (c == 2);
            #1;
            chk("beq_stall", V_DE_BR_STALL, 1'b1);
            chk("beq_ld_fe", LD_FE, c == 2);
            chk("beq_flush", FE_FLUSH, c == 2);
            chk("beq_de_v_in", DE_V_IN, 1'b0);
            chk("beq_exe_v_in", EXE_V_IN, 1'b0);
        end
        @(negedge CLK);
        clear_inputs();
        #1;
        chk("beq_run_stall", V_DE_BR_STALL, 1'b0);
        chk("beq_run_ld_fe", LD_FE, 1'b1);

        // JAL timeout after exactly 15 wait cycles
        issue(JAL_00);
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            clear_inputs();
            #1;
            chk("jal_stall", V_DE_BR_STALL, 1'b1);
            chk("jal_ld_fe", LD_FE, i == 14);
            chk("jal_br_err_early", BR_ERR, 1'b0);
        end
        @(negedge CLK); #1;
        chk("jal_exit_stall", V_DE_BR_STALL, 1'b0);
        chk("jal_br_err", BR_ERR, 1'b1);

        // MEM_STALL freezes BR_WAIT and masks resolve pulses
        issue(BEQ_00);
        @(negedge CLK);
        clear_inputs();
        #1;
        chk("ms_pre_stall", V_DE_BR_STALL, 1'b1);
        for (int s = 0; s < 4; s++) begin
            @(negedge CLK);
            MEM_STALL = 1'b1; EXE_BR_RES = 1'b1; EXE_BR_TAKEN = 1'b1;
            #1;
            chk("ms_ld_fe", LD_FE, 1'b0);
            chk("ms_ld_de", LD_DE, 1'b0);
            chk("ms_ld_agex", LD_AGEX, 1'b0);
            chk("ms_flush", FE_FLUSH, 1'b0);
            chk("ms_br_stall", V_DE_BR_STALL, 1'b1);
        end
        for (int j = 0; j < 14; j++) begin
            @(negedge CLK);
            clear_inputs();
            #1;
            chk("ms_wait_stall", V_DE_BR_STALL, 1'b1);
            chk("ms_wait_ld_fe", LD_FE, j == 13);
        end
        @(negedge CLK); #1;
        chk("ms_exit_stall", V_DE_BR_STALL, 1'b0);
        chk("br_err_sticky", BR_ERR, 1'b1);

        // ECALL drain, halt, resume (RESUME during DRAIN is ignored)
        issue(ECALL);
        for (int d = 0; d < 3; d++) begin
            @(negedge CLK);
            clear_inputs();
            RESUME = (d == 0);
            #1;
            chk("drain_ld_fe", LD_FE, 1'b0);
            chk("drain_ld_de", LD_DE, 1'b1);
            chk("drain_ld_agex", LD_AGEX, 1'b1);
            chk("drain_de_v_in", DE_V_IN, 1'b0);
            chk("drain_exe_v_in", EXE_V_IN, 1'b0);
            chk("drain_halted", HALTED, 1'b0);
        end
        @(negedge CLK);
        RESUME = 1'b0;
        #1;
        chk("halt_halted", HALTED, 1'b1);
        chk("halt_ld_fe", LD_FE, 1'b0);
        chk("halt_ld_de", LD_DE, 1'b0);
        chk("halt_ld_agex", LD_AGEX, 1'b0);
        @(negedge CLK);
        RESUME = 1'b1;
        #1;
        chk("resume_cycle_halted", HALTED, 1'b1);
        chk("resume_cycle_ld_fe", LD_FE, 1'b0);
        @(negedge CLK);
        RESUME = 1'b0;
        #1;
        chk("resumed_halted", HALTED, 1'b0);
        chk("resumed_ld_fe", LD_FE, 1'b1);

        // reset in DRAIN
        issue(ECALL);
        @(negedge CLK);
        clear_inputs();
        RESET = 1'b1;
        #1;
        chk("rst_drain_ld_fe", LD_FE, 1'b1);
        chk("rst_drain_de_v_in", DE_V_IN, 1'b0);
        chk("rst_drain_exe_v_in", EXE_V_IN, 1'b0);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("rst_drain_run_ld_fe", LD_FE, 1'b1);
        chk("rst_drain_br_err", BR_ERR, 1'b0);
        chk("rst_drain_halted", HALTED, 1'b0);
        @(negedge CLK); #1;
        chk("rst_drain_run2_ld_fe", LD_FE, 1'b1);

        // reset in HALT
        issue(ECALL);
        for (int d = 0; d < 3; d++) begin
            @(negedge CLK);
            clear_inputs();
        end
        @(negedge CLK); #1;
        chk("halt2_halted", HALTED, 1'b1);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("rst_halt_ld_de", LD_DE, 1'b1);
        chk("rst_halt_de_v_in", DE_V_IN, 1'b0);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("rst_halt_halted", HALTED, 1'b0);
        chk("rst_halt_ld_fe", LD_FE, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
